ntt_bram_stream_port: RTL and testbench

- Host-side access engine for the 256x16 true-dual-port coefficient BRAM used by the NTT core.
- Load: accepts a valid/ready stream of 16-bit coefficients and writes them sequentially through BRAM port A.
- Unload: reads the BRAM through port B (1-cycle sync read latency) and emits a valid/ready stream, absorbing backpressure with a small FIFO.
- Sits between the host/DMA stream fabric and the NTT coefficient memory.

---
 rtl/ntt_mem_pkg.sv | 24 ++
 rtl/ntt_bram_stream_port_if.sv | 35 +++
 rtl/ntt_stream_fifo.sv | 49 ++++
 rtl/ntt_bram_stream_port.sv | 107 ++++++++++
 tb/tb_ntt_bram_stream_port.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_mem_pkg.sv
// Shared constants, FSM encoding and address helpers for the NTT coefficient memory port.
package ntt_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bram_stream_port_if.sv
// Bundle of control, load/unload stream and BRAM port signals of the stream port.
// Handshake: a beat transfers on any rising edge where valid && ready; valid never waits on ready.
interface ntt_bram_stream_port_if import ntt_mem_pkg::*; ();

  logic              start_load;
  logic              start_unload;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              bram_we_a;
  logic [ADDR_W-1:0] bram_addr_a;
  logic [DATA_W-1:0] bram_din_a;
  logic              bram_we_b;
  logic [ADDR_W-1:0] bram_addr_b;
  logic [DATA_W-1:0] bram_dout_b;
  state_t            dbg_state;

  modport master (
    input  start_load, start_unload, s_valid, s_data, m_ready, bram_dout_b,
    output busy, done, s_ready, m_valid, m_data,
    output bram_we_a, bram_addr_a, bram_din_a, bram_we_b, bram_addr_b, dbg_state
  );

  modport slave (
    output start_load, start_unload, s_valid, s_data, m_ready, bram_dout_b,
    input  busy, done, s_ready, m_valid, m_data,
    input  bram_we_a, bram_addr_a, bram_din_a, bram_we_b, bram_addr_b, dbg_state
  );

endinterface

// File: rtl/ntt_stream_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; FIFO_DEPTH must be a power of 2.
module ntt_stream_fifo #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int DATA_W     = 16,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [PTR_W:0]    o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != (PTR_W+1)'(FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ntt_bram_stream_port.sv
// Host stream <-> NTT coefficient BRAM engine: load via port A, unload via port B into an output FIFO.
// Define NTT_STREAM_BITREV_EN to unload in bit-reversed address order.
module ntt_bram_stream_port import ntt_mem_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_bram_stream_port_if.master bus
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_pop_cnt;
  logic              r_pend;
  logic [FCNT_W-1:0] w_fifo_count;
  logic [FCNT_W:0]   w_occupancy;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_beat;
  logic              w_issue;
  logic              w_m_valid;
  logic              w_pop;
  logic              w_last_beat;
  logic              w_last_pop;

`ifdef NTT_STREAM_BITREV_EN
  assign w_rd_addr = bit_reverse(r_rd_cnt[ADDR_W-1:0]);
`else
  assign w_rd_addr = r_rd_cnt[ADDR_W-1:0];
`endif

  // Registered occupancy plus the read still in the BRAM pipe; m_ready never feeds issue.
  assign w_occupancy = {1'b0, w_fifo_count} + (FCNT_W+1)'(r_pend);
  assign w_issue     = (r_state == ST_UNLOAD) && (r_rd_cnt < CNT_W'(DEPTH)) &&
                       (w_occupancy < (FCNT_W+1)'(FIFO_DEPTH));
  assign w_beat      = (r_state == ST_LOAD) && bus.s_valid;
  assign w_m_valid   = (w_fifo_count != '0);
  assign w_pop       = w_m_valid && bus.m_ready;
  assign w_last_beat = w_beat && (r_wr_cnt == CNT_W'(DEPTH - 1));
  assign w_last_pop  = w_pop && (r_pop_cnt == CNT_W'(DEPTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_load)        w_next = ST_LOAD;
        else if (bus.start_unload) w_next = ST_UNLOAD;
      end
      ST_LOAD:   if (w_last_beat) w_next = ST_FIN;
      ST_UNLOAD: if (w_last_pop)  w_next = ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_pop_cnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_issue;
      if (r_state == ST_IDLE) begin
        r_wr_cnt  <= '0;
        r_rd_cnt  <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_beat)  r_wr_cnt  <= r_wr_cnt + 1'b1;
        if (w_issue) r_rd_cnt  <= r_rd_cnt + 1'b1;
        if (w_pop)   r_pop_cnt <= r_pop_cnt + 1'b1;
      end
    end
  end

  ntt_stream_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pend),
    .i_din   (bus.bram_dout_b),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_UNLOAD);
  assign bus.done        = (r_state == ST_FIN);
  assign bus.s_ready     = (r_state == ST_LOAD);
  assign bus.m_valid     = w_m_valid;
  assign bus.m_data      = w_m_valid ? w_head : '0;
  assign bus.bram_we_a   = w_beat;
  assign bus.bram_addr_a = w_beat ? r_wr_cnt[ADDR_W-1:0] : '0;
  assign bus.bram_din_a  = w_beat ? bus.s_data : '0;
  assign bus.bram_we_b   = 1'b0;
  assign bus.bram_addr_b = w_issue ? w_rd_addr : '0;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ntt_bram_stream_port.sv
// Directed bench for ntt_bram_stream_port with a 256x16 dual-port BRAM model.
module tb_ntt_bram_stream_port;
  import ntt_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_bram_stream_port_if bus ();

  ntt_bram_stream_port #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_we_a) bram[bus.bram_addr_a] <= bus.bram_din_a;
    bus.bram_dout_b <= bram[bus.bram_addr_b];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int mode, input int i);
    logic [DATA_W-1:0] v;
    v = DATA_W'(i);
    if (mode == 0)      return DATA_W'(i * 3);
    else if (mode == 1) return v ^ 16'hA5A5;
    else                return v;
  endfunction

  function automatic int exp_addr(input int k);
`ifdef NTT_STREAM_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < ADDR_W; b++) if (k[b]) r = r | (1 << (ADDR_W - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  // Monitors sample mid-cycle, between the driving and the active edges.
  int                cyc = 0;
  int                done_cnt = 0;
  int                first_pop_cyc = 0;
  int                last_pop_cyc = 0;
  logic [DATA_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  logic [DATA_W-1:0] got_q [$];
  logic [DATA_W-1:0] exp_q [$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.bram_we_a) begin
        wr_addr_q.push_back(DATA_W'(bus.bram_addr_a));
        wr_data_q.push_back(bus.bram_din_a);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (got_q.size() == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        got_q.push_back(bus.m_data);
      end
      if (bus.done) done_cnt++;
      if (prev_stall) begin
        check("m_valid_hold", 32'(bus.m_valid), 32'd1);
        check("m_data_hold", 32'(bus.m_data), 32'(prev_data));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, bus.busy, bus.done, bus.s_ready, bus.m_valid,
                          bus.bram_we_a, bus.bram_we_b}, 32'd0);
    check({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    check({tag, "_addr_a"}, 32'(bus.bram_addr_a), 32'd0);
    check({tag, "_din_a"}, 32'(bus.bram_din_a), 32'd0);
    check({tag, "_addr_b"}, 32'(bus.bram_addr_b), 32'd0);
  endtask

  task automatic run_load(input int mode, input bit rand_valid, input bit poke);
    int   idx;
    int   busy_low;
    bit   fin;
    logic acc;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    idx = 0;
    busy_low = 0;
    fin = 1'b0;
    tick();
    bus.start_load   = 1'b1;
    bus.start_unload = poke;
    bus.s_valid      = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.s_data       = pat(mode, 0);
    tick();
    bus.start_load   = 1'b0;
    bus.start_unload = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("load_state", 32'(bus.dbg_state), 32'(ST_LOAD));
        check("load_s_ready", 32'(bus.s_ready), 32'd1);
      end
      if (!bus.busy) busy_low++;
      acc = bus.s_valid && bus.s_ready;
      tick();
      if (acc) begin
        idx++;
        bus.s_data = pat(mode, idx);
      end
      bus.s_valid      = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start_unload = poke && acc && (idx == 10);
      if (idx == DEPTH) fin = 1'b1;
    end
    bus.start_unload = 1'b0;
    check("load_finished", 32'(fin), 32'd1);
    @(negedge clk);
    check("load_fin_done", 32'(bus.done), 32'd1);
    check("load_fin_s_ready", 32'(bus.s_ready), 32'd0);
    check("load_fin_busy", 32'(bus.busy), 32'd0);
    check("load_fin_we_a", 32'(bus.bram_we_a), 32'd0);
    tick();
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("load_done_pulse", 32'(bus.done), 32'd0);
    check("load_idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("load_done_count", 32'(done_cnt), 32'd1);
    check("load_busy_gaps", 32'(busy_low), 32'd0);
    check("load_write_count", 32'(wr_addr_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < wr_addr_q.size(); i++) begin
      check("load_wr_addr", 32'(wr_addr_q[i]), 32'(i));
      check("load_wr_data", 32'(wr_data_q[i]), 32'(pat(mode, i)));
    end
  endtask

  task automatic run_unload(input bit rand_ready, input int mode, input int abort_at);
    int   npop;
    bit   fin;
    bit   aborted;
    logic pop;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(pat(mode, exp_addr(k)));
    done_cnt = 0;
    npop = 0;
    fin = 1'b0;
    aborted = 1'b0;
    tick();
    bus.m_ready      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.start_unload = 1'b1;
    tick();
    bus.start_unload = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (!rand_ready && c < 3) check("unload_latency_valid", 32'(bus.m_valid), 32'(c == 2));
      if (c == 0) begin
        check("unload_busy", 32'(bus.busy), 32'd1);
        check("unload_first_addr", 32'(bus.bram_addr_b), 32'(exp_addr(0)));
        check("unload_we_b", 32'(bus.bram_we_b), 32'd0);
      end
      if (!rand_ready && c == 2) check("unload_first_data", 32'(bus.m_data), 32'(pat(mode, exp_addr(0))));
      pop = bus.m_valid && bus.m_ready;
      tick();
      if (pop) npop++;
      bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at > 0 && npop == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (pop && npop == DEPTH) fin = 1'b1;
    end
    if (aborted) begin
      bus.m_ready = 1'b0;
      @(negedge clk);
      check_zero("abort");
      check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_pop_count", 32'(got_q.size()), 32'(abort_at));
      for (int k = 0; k < got_q.size(); k++) check("abort_data", 32'(got_q[k]), 32'(exp_q[k]));
    end else begin
      check("unload_finished", 32'(fin), 32'd1);
      @(negedge clk);
      check("unload_fin_done", 32'(bus.done), 32'd1);
      check("unload_fin_m_valid", 32'(bus.m_valid), 32'd0);
      check("unload_fin_busy", 32'(bus.busy), 32'd0);
      tick();
      bus.m_ready = 1'b0;
      @(negedge clk);
      check("unload_done_pulse", 32'(bus.done), 32'd0);
      check("unload_done_count", 32'(done_cnt), 32'd1);
      check("unload_word_count", 32'(got_q.size()), 32'(DEPTH));
      if (!rand_ready) check("unload_back_to_back", 32'(last_pop_cyc - first_pop_cyc), 32'(DEPTH - 1));
      for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
        check("unload_data", 32'(got_q[k]), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    bus.start_load   = 1'b0;
    bus.start_unload = 1'b0;
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.m_ready      = 1'b0;
    @(negedge clk);
    check_zero("reset");
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    run_load(0, 1'b0, 1'b1);
    run_load(1, 1'b1, 1'b0);
    run_unload(1'b0, 1, -1);
    run_unload(1'b1, 1, -1);
    run_unload(1'b0, 1, 100);
    run_unload(1'b0, 1, -1);
    run_load(2, 1'b0, 1'b0);
    run_unload(1'b0, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
